// File: rtl/alu_muldiv_seq_pkg.sv
// Shared constants for the multiply/divide sequencer: ALU op codes, FSM states, mode values.
package alu_muldiv_seq_pkg;

    localparam logic [2:0] ALU_RLL = 3'b000;
    localparam logic [2:0] ALU_SLL = 3'b001;
    localparam logic [2:0] ALU_SRA = 3'b010;
    localparam logic [2:0] ALU_SRL = 3'b011;
    localparam logic [2:0] ALU_ADD = 3'b100;
    localparam logic [2:0] ALU_OR  = 3'b101;
    localparam logic [2:0] ALU_XOR = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    typedef enum logic {
        MODE_MUL = 1'b0,
        MODE_DIV = 1'b1
    } mode_e;

endpackage

// File: rtl/alu_muldiv_seq_muldiv_dp.sv
// Operand/result registers for shift-add multiply and restoring divide.
// hi/lo hold {product} during multiply and {remainder, quotient} during divide.
module muldiv_dp
    import alu_muldiv_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  mode_e            load_mode_i,
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    input  logic             step_i,
    input  logic             step_div_i,
    input  logic [WIDTH-1:0] alu_out_i,
    input  logic             alu_cout_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic [WIDTH-1:0] opb_o,
    output logic [WIDTH-1:0] div_s_o
);

    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] div_s;
    logic             qbit;

    // Partial remainder shifted left by one; its lost MSB forces a quotient 1.
    assign div_s = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
    assign qbit  = hi_q[WIDTH-1] | alu_cout_i;

    always_comb begin
        hi_d  = hi_q;
        lo_d  = lo_q;
        opb_d = opb_q;
        if (load_i) begin
            opb_d = op_b_i;
            if (load_mode_i == MODE_DIV && op_b_i == '0) begin
                hi_d = op_a_i;
                lo_d = '1;
            end else begin
                hi_d = '0;
                lo_d = op_a_i;
            end
        end else if (step_i) begin
            if (step_div_i) begin
                hi_d = qbit ? alu_out_i : div_s;
                lo_d = {lo_q[WIDTH-2:0], qbit};
            end else if (lo_q[0]) begin
                {hi_d, lo_d} = {alu_cout_i, alu_out_i, lo_q[WIDTH-1:1]};
            end else begin
                {hi_d, lo_d} = {1'b0, hi_q, lo_q[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hi_q  <= '0;
            lo_q  <= '0;
            opb_q <= '0;
        end else begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            opb_q <= opb_d;
        end
    end

    assign hi_o    = hi_q;
    assign lo_o    = lo_q;
    assign opb_o   = opb_q;
    assign div_s_o = div_s;

endmodule

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle multiply/divide sequencer that borrows the shared ALU one add per granted cycle.
// FSM and iteration counter live here; the operand/result registers live in muldiv_dp.
module alu_muldiv_seq
    import alu_muldiv_seq_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_hi,
    output logic [WIDTH-1:0] result_lo,
    output logic             div_by_zero,
    output logic             alu_req,
    input  logic             alu_gnt,
    output logic [WIDTH-1:0] alu_A,
    output logic [WIDTH-1:0] alu_B,
    output logic             alu_Cin,
    output logic [2:0]       alu_Op,
    output logic             alu_invA,
    output logic             alu_invB,
    output logic             alu_sign,
    input  logic [WIDTH-1:0] alu_Out,
    input  logic             alu_Cout
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dbz_q, dbz_d;
    logic             load, step;
    logic [WIDTH-1:0] hi, lo, opb, div_s;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dbz_d   = dbz_q;
        load    = 1'b0;
        step    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    load  = 1'b1;
                    cnt_d = '0;
                    dbz_d = (mode == MODE_DIV) && (op_b == '0);
                    if (mode == MODE_MUL)
                        state_d = S_MUL;
                    else if (op_b == '0)
                        state_d = S_DONE;
                    else
                        state_d = S_DIV;
                end
            end
            S_MUL, S_DIV: begin
                // A withheld grant freezes everything, so the ALU operands stay put.
                if (alu_gnt) begin
                    step  = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST)
                        state_d = S_DONE;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy        = (state_q != S_IDLE);
        done        = (state_q == S_DONE);
        div_by_zero = (state_q == S_DONE) && dbz_q;
        alu_req     = 1'b0;
        alu_A       = '0;
        alu_B       = '0;
        alu_Cin     = 1'b0;
        alu_Op      = ALU_RLL;
        alu_invA    = 1'b0;
        alu_invB    = 1'b0;
        alu_sign    = 1'b0;
        if (state_q == S_MUL) begin
            alu_req = 1'b1;
            alu_A   = hi;
            alu_B   = opb;
            alu_Op  = ALU_ADD;
        end else if (state_q == S_DIV) begin
            // s - dvs computed as s + ~dvs + 1; carry-out means no borrow.
            alu_req  = 1'b1;
            alu_A    = div_s;
            alu_B    = opb;
            alu_Op   = ALU_ADD;
            alu_invB = 1'b1;
            alu_Cin  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dbz_q   <= dbz_d;
        end
    end

    muldiv_dp #(
        .WIDTH(WIDTH)
    ) u_dp (
        .clk_i       (clk),
        .rst_i       (rst),
        .load_i      (load),
        .load_mode_i (mode_e'(mode)),
        .op_a_i      (op_a),
        .op_b_i      (op_b),
        .step_i      (step),
        .step_div_i  (state_q == S_DIV),
        .alu_out_i   (alu_Out),
        .alu_cout_i  (alu_Cout),
        .hi_o        (hi),
        .lo_o        (lo),
        .opb_o       (opb),
        .div_s_o     (div_s)
    );

    assign result_hi = hi;
    assign result_lo = lo;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Scoreboard bench for alu_muldiv_seq: behavioural ALU on the alu_* ports, arithmetic reference model.
module tb_alu_muldiv_seq;
    import alu_muldiv_seq_pkg::*;

    typedef struct {
        logic [15:0] hi;
        logic [15:0] lo;
        logic        dbz;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic [15:0] op_a = '0;
    logic [15:0] op_b = '0;
    logic        busy, done, div_by_zero, alu_req;
    logic [15:0] result_hi, result_lo;
    logic        alu_gnt = 1'b1;
    logic [15:0] alu_A, alu_B, alu_Out;
    logic        alu_Cin, alu_invA, alu_invB, alu_sign, alu_Cout;
    logic [2:0]  alu_Op;

    int   n_pass = 0;
    int   n_total = 0;
    int   gmode = 0;
    bit   req_seen = 1'b0;
    exp_t sb_q[$];

    alu_muldiv_seq dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .op_a(op_a), .op_b(op_b),
        .busy(busy), .done(done), .result_hi(result_hi), .result_lo(result_lo),
        .div_by_zero(div_by_zero), .alu_req(alu_req), .alu_gnt(alu_gnt),
        .alu_A(alu_A), .alu_B(alu_B), .alu_Cin(alu_Cin), .alu_Op(alu_Op),
        .alu_invA(alu_invA), .alu_invB(alu_invB), .alu_sign(alu_sign),
        .alu_Out(alu_Out), .alu_Cout(alu_Cout)
    );

    always #5 clk = ~clk;

    function automatic logic [16:0] alu_fn(input logic [15:0] a, input logic [15:0] b,
                                           input logic cin, input logic inva, input logic invb,
                                           input logic [2:0] op);
        logic [15:0] aa, bb;
        logic [31:0] dbl;
        logic [16:0] r;
        aa  = inva ? ~a : a;
        bb  = invb ? ~b : b;
        dbl = {aa, aa} << bb[3:0];
        case (op)
            ALU_ADD: r = {1'b0, aa} + {1'b0, bb} + {16'b0, cin};
            ALU_OR:  r = {1'b0, aa | bb};
            ALU_XOR: r = {1'b0, aa ^ bb};
            ALU_AND: r = {1'b0, aa & bb};
            ALU_SLL: r = {1'b0, aa << bb[3:0]};
            ALU_SRL: r = {1'b0, aa >> bb[3:0]};
            ALU_SRA: r = {1'b0, 16'($signed(aa) >>> bb[3:0])};
            default: r = {1'b0, dbl[31:16]};
        endcase
        return r;
    endfunction

    assign {alu_Cout, alu_Out} = alu_fn(alu_A, alu_B, alu_Cin, alu_invA, alu_invB, alu_Op);

    function automatic exp_t model(input logic m, input logic [15:0] a, input logic [15:0] b);
        exp_t        e;
        logic [31:0] p;
        if (!m) begin
            p     = {16'b0, a} * {16'b0, b};
            e.hi  = p[31:16];
            e.lo  = p[15:0];
            e.dbz = 1'b0;
        end else if (b == 16'd0) begin
            e.hi  = a;
            e.lo  = 16'hFFFF;
            e.dbz = 1'b1;
        end else begin
            e.hi  = a % b;
            e.lo  = a / b;
            e.dbz = 1'b0;
        end
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Grant generator: 0 = always granted, 1 = alternate, 2 = random.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (gmode)
                1:       alu_gnt = ~alu_gnt;
                2:       alu_gnt = 1'($urandom_range(0, 1));
                default: alu_gnt = 1'b1;
            endcase
        end
    end

    // Result monitor: pops the scoreboard whenever done is presented.
    always @(negedge clk) begin
        exp_t e;
        if (alu_req) req_seen = 1'b1;
        if (!rst && done) begin
            if (sb_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_done: got done=1 result=0x%0h, expected no done", {result_hi, result_lo});
            end else begin
                e = sb_q.pop_front();
                check("result", {result_hi, result_lo}, {e.hi, e.lo});
                check("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
                check("alu_idle_in_done", {alu_req, alu_A, alu_Op, alu_Cin, alu_invA, alu_invB, alu_sign}, 32'd0);
            end
        end
    end

    // Stall monitor: alu_* must not move across a cycle whose grant was withheld.
    logic        prev_stall = 1'b0;
    logic [35:0] prev_alu = '0;
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && alu_req)
                check("alu_stable_stall", 32'({alu_A, alu_B} ^ prev_alu[31:0]) | 32'({alu_Op, alu_Cin} ^ prev_alu[35:32]), 32'd0);
            prev_stall = alu_req && !alu_gnt;
            prev_alu   = {alu_Op, alu_Cin, alu_A, alu_B};
        end
    end

    task automatic issue(input logic m, input logic [15:0] a, input logic [15:0] b,
                         input int gm, input bit push);
        @(negedge clk);
        start = 1'b1;
        mode  = m;
        op_a  = a;
        op_b  = b;
        gmode = gm;
        if (push) sb_q.push_back(model(m, a, b));
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Counts edges from the accepting edge until done is seen.
    task automatic wait_done(output int edges);
        edges = 1;
        while (!done && edges < 400) begin
            @(posedge clk);
            #1;
            edges++;
        end
        if (!done) begin
            n_total++;
            $display("FAIL done_timeout: got no done after %0d cycles, expected done", edges);
        end
    endtask

    task automatic run(input string name, input logic m, input logic [15:0] a,
                       input logic [15:0] b, input int gm, input int lat);
        int edges;
        issue(m, a, b, gm, 1'b1);
        wait_done(edges);
        if (lat > 0) check({name, "_latency"}, 32'(edges), 32'(lat));
        @(posedge clk);
        #1;
        check({name, "_busy_after"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int edges;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", {result_hi, result_lo}, 32'd0);
        check("rst_alu", {alu_req, alu_A, alu_Op, div_by_zero}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run("mul_1234x10", 1'b0, 16'h1234, 16'h0010, 0, 17);
        run("mul_ffffxffff", 1'b0, 16'hFFFF, 16'hFFFF, 0, 17);
        run("div_ffff_10", 1'b1, 16'hFFFF, 16'h0010, 0, 17);
        run("div_8000_ffff", 1'b1, 16'h8000, 16'hFFFF, 0, 17);

        req_seen = 1'b0;
        run("div_by_0", 1'b1, 16'h0064, 16'h0000, 0, 1);
        check("div0_no_alu_req", 32'(req_seen), 32'd0);

        run("mul_stall", 1'b0, 16'h00FF, 16'h0101, 1, 33);
        gmode = 0;

        // Reset in the middle of a multiply: aborts with no done and clears results.
        issue(1'b0, 16'h5555, 16'h3333, 0, 1'b0);
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_result", {result_hi, result_lo}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("abort_idle", 32'(busy), 32'd0);

        // A start raised while busy must be dropped, not queued.
        issue(1'b0, 16'h0003, 16'h0005, 0, 1'b1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        mode  = 1'b1;
        op_a  = 16'h0007;
        op_b  = 16'h0000;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(edges);
        repeat (5) @(posedge clk);
        #1;
        check("ignored_start_result", {result_hi, result_lo}, 32'h0000_000F);
        check("ignored_start_busy", 32'(busy), 32'd0);

        for (int i = 0; i < 40; i++) begin
            logic [15:0] a, b;
            logic        m;
            int          gm;
            m  = 1'($urandom_range(0, 1));
            a  = 16'($urandom);
            case ($urandom_range(0, 4))
                0:       b = 16'h0000;
                1:       b = 16'($urandom_range(1, 15));
                default: b = 16'($urandom);
            endcase
            gm = ($urandom_range(0, 1) == 0) ? 0 : 2;
            run("rand", m, a, b, gm, 0);
            gmode = 0;
        end

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
